// File: rtl/eggtimer_pkg.sv
// Shared egg-timer constants and the packed-digit slice helper.
package eggtimer_pkg;

    localparam logic [15:0] MAX_MMSS   = 16'h5959;
    localparam logic [23:0] MAX_HHMMSS = 24'h235959;

    // Digit i of a packed vector whose digits are w bits wide.
    function automatic logic [15:0] digit_of(input logic [63:0] vec,
                                             input int unsigned i,
                                             input int unsigned w = 4);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 16'((vec >> (i * w)) & mask);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One counter digit with modulus max_i, clamped load, and up/down stepping.
module bcd_digit_cell #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_digit_i,
    input  logic             step_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             is_terminal_o,
    output logic             next_terminal_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_digit_i > max_i) ? max_i : load_digit_i;
        end else if (step_i) begin
            if (up_i) begin
                count_d = (count_q == max_i) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = (count_q == '0) ? max_i : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o         = count_q;
    assign is_terminal_o   = up_i ? (count_q == max_i) : (count_q == '0);
    // Terminal status of the value this digit will hold after the edge.
    assign next_terminal_o = up_i ? (count_d == max_i) : (count_d == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD up/down counter: ripple-step chain, halt gating, done pulse.
module bcd_cascade_counter
    import eggtimer_pkg::*;
#(
    parameter int unsigned              DIGITS  = 4,
    parameter int unsigned              WIDTH   = 4,
    parameter logic [DIGITS*WIDTH-1:0]  MAX_VEC = MAX_MMSS,
    parameter bit                       WRAP    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [DIGITS*WIDTH-1:0] load_value_i,
    input  logic                    enable_i,
    input  logic                    up_i,
    output logic [DIGITS*WIDTH-1:0] count_o,
    output logic                    at_terminal_o,
    output logic                    done_o
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] next_term;
    logic [DIGITS-1:0] step;
    logic              run;
    logic              done_q, done_d;

    assign at_terminal_o = &term;
    // Load suppresses stepping; a non-wrapping counter freezes at its terminal.
    assign run = enable_i & ~load_i & (WRAP | ~at_terminal_o);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [WIDTH-1:0] MaxDigit = WIDTH'(digit_of(64'(MAX_VEC), i, WIDTH));

        if (i == 0) begin : g_first
            assign step[i] = run;
        end else begin : g_rest
            assign step[i] = step[i-1] & term[i-1];
        end

        bcd_digit_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk             (clk),
            .reset           (reset),
            .load_i          (load_i),
            .load_digit_i    (load_value_i[i*WIDTH +: WIDTH]),
            .step_i          (step[i]),
            .up_i            (up_i),
            .max_i           (MaxDigit),
            .count_o         (count_o[i*WIDTH +: WIDTH]),
            .is_terminal_o   (term[i]),
            .next_terminal_o (next_term[i])
        );
    end

    assign done_d = run & (&next_term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule
